// File: rtl/seq_divider_pkg.sv
// div_pkg -- shared definitions for the seq_divider slice.
//   DEFAULT_WIDTH : default operand/quotient/remainder width
//   div_state_e   : divider control states (IDLE, BUSY, DONE)
package div_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if -- request/result bundle of the sequential divider.
//   start, flush, sign_mode, a, b : requester -> divider
//   busy, done, q, r, dz          : divider -> requester
// Modports: master (requester side), slave (divider side).
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic             flush;
    logic             sign_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             dz;

    modport master (
        output start, flush, sign_mode, a, b,
        input  busy, done, q, r, dz
    );

    modport slave (
        input  start, flush, sign_mode, a, b,
        output busy, done, q, r, dz
    );

endinterface

// File: rtl/seq_divider_sign_fix.sv
// div_sign_fix -- two's-complement adaption around the unsigned divider core.
//   sign_mode, a, b : raw request operands
//   a_mag, b_mag    : operand magnitudes fed to the core
//   neg_q_d/neg_r_d : result sign flags to latch with the operands
//   neg_q/neg_r     : latched sign flags
//   q_in/r_in       : unsigned core results; q_out/r_out : signed results
// Only instantiated when SEQ_DIVIDER_SIGNED_EN is defined.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_mag,
    output logic [WIDTH-1:0] b_mag,
    output logic             neg_q_d,
    output logic             neg_r_d,
    input  logic             neg_q,
    input  logic             neg_r,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] r_in,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] r_out
);

    logic a_neg;
    logic b_neg;

    // The most-negative value maps to itself under negation, which reads
    // correctly as its unsigned magnitude.
    assign a_neg   = sign_mode & a[WIDTH-1];
    assign b_neg   = sign_mode & b[WIDTH-1];
    assign a_mag   = a_neg ? -a : a;
    assign b_mag   = b_neg ? -b : b;
    assign neg_q_d = a_neg ^ b_neg;
    assign neg_r_d = a_neg;
    assign q_out   = neg_q ? -q_in : q_in;
    assign r_out   = neg_r ? -r_in : r_in;

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- restoring shift-subtract divider, one quotient bit per cycle.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : seq_divider_if.slave (start/flush/sign_mode/a/b in,
//         busy/done/q/r/dz out)
// Optional macro SEQ_DIVIDER_SIGNED_EN adds signed operation (sign_mode=1).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    div_state_e       state_q, state_d;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [CW-1:0]    cnt_q;
    logic             zero_q;
    logic             neg_q_q, neg_r_q;
    logic [WIDTH-1:0] q_q, r_q;
    logic             dz_q;

    logic             accept, finish;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             neg_q_d, neg_r_d;
    logic [WIDTH-1:0] r_core, q_fix, r_fix;
    logic [WIDTH+1:0] trial, diff;

    assign accept = (state_q != BUSY) && bus.start && !bus.flush;
    // A zero divisor skips the iterations and completes one edge after accept.
    assign finish = (state_q == BUSY) && !bus.flush && (zero_q || cnt_q == LAST);

    // quo_q still holds the untouched dividend magnitude when dividing by zero.
    assign r_core = zero_q ? quo_q : rem_q[WIDTH-1:0];

    assign trial = {rem_q, quo_q[WIDTH-1]};
    assign diff  = trial - {2'b00, dvs_q};

`ifdef SEQ_DIVIDER_SIGNED_EN
    div_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
        .sign_mode (bus.sign_mode),
        .a         (bus.a),
        .b         (bus.b),
        .a_mag     (a_mag),
        .b_mag     (b_mag),
        .neg_q_d   (neg_q_d),
        .neg_r_d   (neg_r_d),
        .neg_q     (neg_q_q),
        .neg_r     (neg_r_q),
        .q_in      (quo_q),
        .r_in      (r_core),
        .q_out     (q_fix),
        .r_out     (r_fix)
    );
`else
    logic [2:0] unused_sign;

    assign a_mag       = bus.a;
    assign b_mag       = bus.b;
    assign neg_q_d     = 1'b0;
    assign neg_r_d     = 1'b0;
    assign q_fix       = quo_q;
    assign r_fix       = r_core;
    assign unused_sign = {bus.sign_mode, neg_q_q, neg_r_q};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: state_d = accept ? BUSY : IDLE;
            BUSY:       if (finish) state_d = DONE;
            default:    state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            dz_q    <= 1'b0;
        end else if (accept) begin
            rem_q   <= '0;
            quo_q   <= a_mag;
            dvs_q   <= b_mag;
            cnt_q   <= '0;
            zero_q  <= (b_mag == '0);
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end else if (state_q == BUSY && !bus.flush) begin
            if (finish) begin
                q_q  <= zero_q ? '1 : q_fix;
                r_q  <= r_fix;
                dz_q <= zero_q;
            end else begin
                rem_q <= diff[WIDTH+1] ? trial[WIDTH:0] : diff[WIDTH:0];
                quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.busy = (state_q == BUSY);
    assign bus.done = (state_q == DONE);
    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.dz   = dz_q;

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand, quotient and remainder width in bits (legal 4..64).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request a division; sampled only when busy=0.
REQ-005 The block SHALL have port flush, input, 1, synchronous cancel of any operation in progress.
REQ-006 The block SHALL have port sign_mode, input, 1, 1 = signed two's-complement operation; sampled with start.
REQ-007 The block SHALL have ports a and b, input, WIDTH, dividend and divisor; sampled with start.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1, single-cycle pulse when q, r and dz are valid.
REQ-010 The block SHALL have ports q and r, output, WIDTH, quotient and remainder, held from done until the next accepted start.
REQ-011 The block SHALL have port dz, output, 1, divide-by-zero flag, valid with done.

Function
REQ-012 The block SHALL implement states IDLE, BUSY and DONE.
REQ-013 IDLE or DONE with start=1 and flush=0 SHALL latch operands, set busy=1 and enter BUSY; if b=0, it SHALL instead enter DONE on the next edge.
REQ-014 BUSY SHALL run restoring shift-subtract, one quotient bit per cycle, MSB first, for exactly WIDTH cycles, using an internal remainder of WIDTH+1 bits.
REQ-015 done SHALL assert exactly WIDTH+1 cycles after the accepting edge (1 cycle for b=0), last exactly one cycle, and coincide with busy falling to 0.
REQ-016 DONE SHALL return to IDLE after one cycle unless start=1, which is accepted back-to-back.
REQ-017 start while busy=1 SHALL be ignored, with no effect on the running operation.
REQ-018 flush=1 SHALL force IDLE on the next edge, clear busy, suppress done and leave q/r/dz at their previous values; flush wins over a simultaneous start.
REQ-019 Unsigned results SHALL satisfy a = q*b + r with 0 <= r < b.
REQ-020 For b=0, the result SHALL be q = all ones, r = a and dz=1; otherwise dz=0.
REQ-021 Operation with a < b SHALL give q=0 and r=a.

Reset
REQ-022 rst=1 SHALL immediately force IDLE and set busy=0, done=0, q=0, r=0, dz=0, regardless of clock, including mid-operation.
REQ-023 After rst deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-024 Macro SEQ_DIVIDER_SIGNED_EN SHALL compile in signed support.
REQ-025 With SEQ_DIVIDER_SIGNED_EN defined and sign_mode=1, operands SHALL be made absolute at start, and the core SHALL run unsigned.
REQ-026 In the same case, q SHALL be negated when the operand signs differ (truncation toward zero), r SHALL take the sign of a, and the result SHALL apply in the cycle done asserts with unchanged latency.
REQ-027 In signed mode, most-negative / -1 SHALL give q = most-negative and r=0 with dz=0; b=0 SHALL give q = all ones, r=a and dz=1.
REQ-028 Without SEQ_DIVIDER_SIGNED_EN, sign_mode SHALL be ignored, and all operations SHALL be unsigned.

Structure
REQ-029 The state enum (IDLE/BUSY/DONE) and the default WIDTH constant SHALL live in the shared package div_pkg.
REQ-030 Sign conversion (abs on entry, negation on exit) SHALL be sub-module div_sign_fix, instantiated only under SEQ_DIVIDER_SIGNED_EN.
REQ-031 The iteration counter SHALL be clog2(WIDTH+1) bits wide.

Verification
REQ-032 With WIDTH=16, a=100, b=7 and a start pulse, the bench SHALL check q=14, r=2, dz=0, with done exactly 17 cycles after start and busy high for cycles 1..16.
REQ-033 With a=5, b=9, the bench SHALL check q=0 and r=5; with a=1234, b=0, it SHALL check done after 1 cycle with q=16'hFFFF, r=1234, dz=1.
REQ-034 With SEQ_DIVIDER_SIGNED_EN and sign_mode=1, the bench SHALL check -7/2 gives q=-3, r=-1, and 16'h8000/16'hFFFF gives q=16'h8000, r=0.
REQ-035 With a start issued on cycle 5 of a 100/7 operation using a=9, b=3, the bench SHALL check that the result remains q=14, r=2 and that exactly one done occurs.
REQ-036 With flush at cycle 8 of an operation, the bench SHALL check busy=0 next cycle, no done, and q/r unchanged; a start on the same cycle as the flush SHALL be ignored.
REQ-037 With rst asserted mid-BUSY between clock edges, the bench SHALL check all outputs zero immediately, and a start 1 cycle after release SHALL produce a correct result.
